// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
package rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] data_word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write-back.
// Latency: rd_busy registered, 1 cycle, reflecting same-cycle set/clear. Backpressure: none.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Set is applied after clears: a newly issued producer outranks a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (sb_set) busy_nxt[sb_addr] = 1'b1;
    busy_nxt[ADDR_W'(ZERO_REG)] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      rd_busy <= '0;
    end else begin
      busy <= busy_nxt;
      for (int i = 0; i < NUM_RD; i++) begin
        rd_busy[i] <= busy_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end
endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with registered reads and RAW scoreboard; RF_BYPASS_EN selects write-first reads.
// Latency: writes visible next cycle, rd_data/rd_busy registered 1 cycle. Backpressure: none, accepts every cycle.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to matching reads.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_nxt;

  // Ascending port order lets the highest-numbered port win an address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != ZERO_A)) begin
          mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_nxt[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_nxt[i*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
        end
      end
`endif
      if (rd_addr[i*ADDR_W +: ADDR_W] == ZERO_A) rd_nxt[i*DATA_W +: DATA_W] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_nxt;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );
endmodule

// File: tb/tb_rf_multiport.sv
// Randomised and directed bench for rf_multiport with a queue-based scoreboard and array reference model.
module tb_rf_multiport;
  import rf_pkg::*;

  localparam int DW  = DEF_DATA_W;
  localparam int AW  = DEF_ADDR_W;
  localparam int NRD = 3;
  localparam int NWR = 2;

  typedef struct {
    logic [NRD*DW-1:0] d;
    logic [NRD-1:0]    b;
    int unsigned       due;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .sb_set  (sb_set),
    .sb_addr (sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus variables, one entry per port
  bit         t_rst;
  bit         t_we [NWR];
  reg_addr_t  t_wa [NWR];
  data_word_t t_wd [NWR];
  reg_addr_t  t_ra [NRD];
  bit         t_ss;
  reg_addr_t  t_sa;

  // reference model state
  data_word_t mm [1<<AW];
  bit         bm [1<<AW];

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic idle();
    t_rst = 0;
    t_ss  = 0;
    t_sa  = '0;
    for (int k = 0; k < NWR; k++) begin t_we[k] = 0; t_wa[k] = '0; t_wd[k] = '0; end
    for (int i = 0; i < NRD; i++) t_ra[i] = '0;
  endtask

  task automatic read_all(input reg_addr_t a);
    for (int i = 0; i < NRD; i++) t_ra[i] = a;
  endtask

  // Drive one cycle, predict its registered response, and queue the prediction.
  task automatic issue();
    exp_t       e;
    bit         nb [1<<AW];
    data_word_t v;
    reg_addr_t  a;
    rst     = t_rst;
    sb_set  = t_ss;
    sb_addr = t_sa;
    for (int k = 0; k < NWR; k++) begin
      wr_en[k]             = t_we[k];
      wr_addr[k*AW +: AW]  = t_wa[k];
      wr_data[k*DW +: DW]  = t_wd[k];
    end
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = t_ra[i];

    e.d   = '0;
    e.b   = '0;
    e.due = cyc + 1;
    if (t_rst) begin
      for (int r = 0; r < (1<<AW); r++) begin mm[r] = '0; bm[r] = 0; end
    end else begin
      for (int r = 0; r < (1<<AW); r++) nb[r] = bm[r];
      for (int k = 0; k < NWR; k++) if (t_we[k]) nb[t_wa[k]] = 0;
      if (t_ss) nb[t_sa] = 1;
      nb[0] = 0;
      for (int i = 0; i < NRD; i++) begin
        a = t_ra[i];
        v = mm[a];
`ifdef RF_BYPASS_EN
        for (int k = 0; k < NWR; k++) if (t_we[k] && t_wa[k] == a) v = t_wd[k];
`endif
        if (a == 0) v = '0;
        e.d[i*DW +: DW] = v;
        e.b[i]          = nb[a];
      end
      for (int k = 0; k < NWR; k++) if (t_we[k] && t_wa[k] != 0) mm[t_wa[k]] = t_wd[k];
      for (int r = 0; r < (1<<AW); r++) bm[r] = nb[r];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each queued prediction once its cycle's outputs are registered.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        total++;
        if (rd_data[i*DW +: DW] !== e.d[i*DW +: DW]) begin
          bad++;
          $display("FAIL rd_data[%0d] cyc=%0d got=%h want=%h", i, cyc, rd_data[i*DW +: DW], e.d[i*DW +: DW]);
        end
        total++;
        if (rd_busy[i] !== e.b[i]) begin
          bad++;
          $display("FAIL rd_busy[%0d] cyc=%0d got=%b want=%b", i, cyc, rd_busy[i], e.b[i]);
        end
      end
    end
  end

  initial begin
    idle();
    t_rst = 1;
    issue();
    issue();

    // reset clears a written register
    idle(); t_we[0] = 1; t_wa[0] = 5'd5; t_wd[0] = 32'hDEADBEEF; issue();
    idle(); read_all(5'd5); issue();
    idle(); t_rst = 1; read_all(5'd5); issue();
    idle(); read_all(5'd5); issue();

    // register 0
    idle(); t_we[0] = 1; t_wa[0] = 5'd0; t_wd[0] = 32'h1234; read_all(5'd0); issue();
    idle(); t_ss = 1; t_sa = 5'd0; read_all(5'd0); issue();
    idle(); read_all(5'd0); issue();

    // same-address write conflict
    idle(); t_we[0] = 1; t_wa[0] = 5'd7; t_wd[0] = 32'h11;
    t_we[1] = 1; t_wa[1] = 5'd7; t_wd[1] = 32'h22; issue();
    idle(); read_all(5'd7); issue();

    // bypass versus read-first
    idle(); t_we[0] = 1; t_wa[0] = 5'd3; t_wd[0] = 32'h55; issue();
    idle(); t_we[1] = 1; t_wa[1] = 5'd3; t_wd[1] = 32'hAA; read_all(5'd3); issue();
    idle(); read_all(5'd3); issue();

    // scoreboard set / clear / set-wins
    idle(); t_ss = 1; t_sa = 5'd9; issue();
    idle(); read_all(5'd9); issue();
    idle(); t_we[0] = 1; t_wa[0] = 5'd9; t_wd[0] = 32'h99; read_all(5'd9); issue();
    idle(); t_ss = 1; t_sa = 5'd9; t_we[1] = 1; t_wa[1] = 5'd9; t_wd[1] = 32'h98; read_all(5'd9); issue();
    idle(); read_all(5'd9); issue();

    // reset in the middle of pending scoreboard state
    idle(); t_ss = 1; t_sa = 5'd4; issue();
    idle(); t_ss = 1; t_sa = 5'd6; t_ra[0] = 5'd4; issue();
    idle(); t_rst = 1; t_ss = 1; t_sa = 5'd8; issue();
    idle(); t_ra[0] = 5'd4; t_ra[1] = 5'd6; t_ra[2] = 5'd8; issue();

    // randomised traffic over a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      t_rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NWR; k++) begin
        t_we[k] = $urandom_range(0, 1);
        t_wa[k] = reg_addr_t'($urandom_range(0, 7));
        t_wd[k] = $urandom;
      end
      for (int i = 0; i < NRD; i++) t_ra[i] = reg_addr_t'($urandom_range(0, 7));
      t_ss = $urandom_range(0, 1);
      t_sa = reg_addr_t'($urandom_range(0, 7));
      issue();
    end

    idle();
    issue();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port general-purpose register file for the pipelined CPU. It replaces the fixed 2-read/1-write file with configurable read and write port counts and a registered read stage. It adds a pending-write scoreboard so decode can detect RAW hazards without an external tracking table. It sits between decode (read and issue side) and write-back (write side).

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth is 2**ADDR_W.
- `NUM_RD`, 2: number of read ports, 1..4.
- `NUM_WR`, 2: number of write ports, 1..2.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  NUM_WR  per-port write enable.
- `wr_addr`  in  NUM_WR*ADDR_W  write addresses, packed, port 0 in LSBs.
- `wr_data`  in  NUM_WR*DATA_W  write data, packed.
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses, packed.
- `rd_data`  out  NUM_RD*DATA_W  registered read data.
- `rd_busy`  out  NUM_RD  registered: the addressed register has a pending producer.
- `sb_set`  in  1  issue strobe: mark `sb_addr` as pending.
- `sb_addr`  in  ADDR_W  destination register of the issuing instruction.

## Operation
- **Array and register 0.** The array holds 2**ADDR_W entries. Entry 0 always reads 0. Writes to entry 0 are ignored. Entry 0 is never busy.
- **Writes.** When `wr_en[k]` is high, `wr_data[k]` is written to `wr_addr[k]` at the posedge.
- **Same-address write conflict.** If both write ports target the same address in one cycle, port NUM_WR-1 wins.
- **Reads.** Each cycle, `rd_data[i]` is loaded with the value of the entry at `rd_addr[i]`, or with the bypassed value (see Configuration).
- **Scoreboard.** Keep one busy bit per entry.
  - `sb_set` sets `busy[sb_addr]`.
  - Any enabled write to an address clears that address's busy bit.
  - If a set and a clear hit the same address in the same cycle, the set wins, because a newer producer has been issued.
- **`rd_busy[i]` value.** `rd_busy[i]` is loaded with the next-state busy bit of `rd_addr[i]`, i.e. after the same-cycle set and clear have been applied.
- **Reset.** When `rst` is high at a posedge:
  - all entries, all busy bits, `rd_data` and `rd_busy` become 0;
  - writes and `sb_set` in that cycle are discarded.
- **Reset mid-operation.** Any pending scoreboard state is lost. Upstream must flush in the same cycle.

## Timing
- **Write latency.** A write is visible in the array one cycle after its posedge.
- **Read latency.** 1 cycle: `rd_data` and `rd_busy` update at the posedge following address presentation and hold until the next posedge.
- **Scoreboard latency.** `sb_set` in cycle N appears on `rd_busy` for reads presented in cycle N; the register is observed at N+1.
- **Read-port independence.** Multiple read ports addressing the same entry return identical values in the same cycle.
- **Reset outputs.** `rd_data` and `rd_busy` read all zeros in the cycle after reset is asserted.

## Configuration
- **`RF_BYPASS_EN` defined:** a read whose address matches an enabled same-cycle write (nonzero address) returns that write data. If several writes match, the winning port's data is returned. `rd_busy` is cleared accordingly. This is write-first behaviour.
- **`RF_BYPASS_EN` undefined:** reads return the pre-write array contents (read-first). `rd_busy` still reflects the next-state busy bit. Bypass must then be done in the forwarding unit.

## Structure
- **Shared package `rf_pkg`:**
  - default `DATA_W` and `ADDR_W` constants;
  - the `ZERO_REG` address constant;
  - a typedef for a register address;
  - a typedef for a data word.
- **Sub-module `rf_scoreboard`:** holds the busy-bit vector, set/clear priority, reset, and per-read-port next-state lookup (parametrised on `ADDR_W` and `NUM_RD`).
- **Top level:** the array, write-conflict resolution and the read/bypass mux stay in the top level.

## Test plan
1. **Reset.** Write 0xDEADBEEF to r5, then assert `rst` for 1 cycle and read r5 -> `rd_data` is 0 and `rd_busy` is 0.
2. **Register 0.** Write 0x1234 to r0 and read r0 on all ports -> 0 on all ports, never busy.
3. **Write conflict.** Port 0 writes 0x11 to r7 and port 1 writes 0x22 to r7 in the same cycle -> a read of r7 next cycle returns 0x22.
4. **Bypass.** Write 0xAA to r3 while reading r3 in the same cycle, where r3 previously held 0x55 -> 0xAA with `RF_BYPASS_EN` defined, 0x55 without it.
5. **Scoreboard.** `sb_set` r9; next cycle read r9 -> `rd_busy` = 1. Write r9 -> the same-cycle read shows `rd_busy` = 0. Simultaneous `sb_set` r9 and a write to r9 -> `rd_busy` = 1.
6. **Reset mid-scoreboard.** Set r4 and r6 busy, then assert `rst` together with `sb_set` r8 -> all busy bits are 0 afterwards, including r8.
